// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types and constants for the modular-exponentiation arbiter
package rsa_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int ABORT_LEN = 2;
    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_FAIL = 1'b1;
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ABORT, RESP} state_t;
endpackage

// File: rtl/modexp_arbiter_if.sv
// modexp_arbiter_if: requester-side and engine-side signals of the modexp arbiter
interface modexp_arbiter_if import rsa_pkg::*; #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH = WIDTH_DEF
);
    logic [NUM_REQ-1:0] req_valid, req_ack, resp_valid;
    logic [NUM_REQ*WIDTH-1:0] req_m, req_e, req_n;
    logic [WIDTH-1:0] resp_result, eng_m, eng_e, eng_n, eng_result;
    logic resp_error, busy, eng_ready, eng_reset, eng_valid;
    modport slave (
        input req_valid, req_m, req_e, req_n, eng_result, eng_valid,
        output req_ack, resp_valid, resp_result, resp_error, busy,
        output eng_m, eng_e, eng_n, eng_ready, eng_reset
    );
    modport master (
        output req_valid, req_m, req_e, req_n, eng_result, eng_valid,
        input req_ack, resp_valid, resp_result, resp_error, busy,
        input eng_m, eng_e, eng_n, eng_ready, eng_reset
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or above ptr with wrap
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);
    always_comb begin
        idx = '0;
        // scan from farthest to nearest so the closest request to ptr wins
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
        any = |req;
        gnt = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/modexp_arbiter.sv
// modexp_arbiter: round-robin sharing of one modexp engine with timeout recovery
module modexp_arbiter import rsa_pkg::*; #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH = WIDTH_DEF,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic clk,
    input logic reset,
    modexp_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    state_t state;
    logic [IW-1:0] ptr, gidx, pick_idx;
    logic [NUM_REQ-1:0] pick;
    logic any, abort_q;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] m_q, e_q, n_q, pick_n;
    rr_arbiter #(.N(NUM_REQ)) u_rr (.req(bus.req_valid), .ptr(ptr), .gnt(pick), .idx(pick_idx), .any(any));
    assign pick_n = bus.req_n[pick_idx * WIDTH +: WIDTH];
    assign bus.eng_m = m_q;
    assign bus.eng_e = e_q;
    assign bus.eng_n = n_q;
    assign bus.eng_reset = reset | abort_q;
    assign bus.busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr <= '0;
            gidx <= '0;
            cnt <= '0;
            abort_q <= 1'b0;
            m_q <= '0;
            e_q <= '0;
            n_q <= '0;
            bus.req_ack <= '0;
            bus.resp_valid <= '0;
            bus.resp_result <= '0;
            bus.resp_error <= ERR_NONE;
            bus.eng_ready <= 1'b0;
        end else begin
            bus.req_ack <= '0;
            bus.resp_valid <= '0;
            cnt <= &cnt ? cnt : cnt + 1'b1;
            case (state)
                IDLE: if (any) begin
                    gidx <= pick_idx;
                    m_q <= bus.req_m[pick_idx * WIDTH +: WIDTH];
                    e_q <= bus.req_e[pick_idx * WIDTH +: WIDTH];
                    n_q <= pick_n;
                    bus.req_ack <= pick;
                    cnt <= '0;
                    if (pick_n < WIDTH'(2)) begin
                        state <= RESP;
                        bus.resp_result <= '0;
                        bus.resp_error <= ERR_FAIL;
                    end else begin
                        state <= LAUNCH;
                        bus.eng_ready <= 1'b1;
                    end
                end
                LAUNCH: if (cnt == CW'(START_CYCLES - 1)) begin
                    state <= WAIT;
                    bus.eng_ready <= 1'b0;
                    cnt <= '0;
                end
                // the first WAIT cycle ignores eng_valid: it may still be the previous result
                WAIT: if (cnt != '0 && bus.eng_valid) begin
                    state <= RESP;
                    bus.resp_valid <= NUM_REQ'(1) << gidx;
                    bus.resp_result <= bus.eng_result;
                    bus.resp_error <= ERR_NONE;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state <= ABORT;
                    abort_q <= 1'b1;
                    cnt <= '0;
                end
                ABORT: if (cnt == CW'(ABORT_LEN - 1)) begin
                    state <= RESP;
                    abort_q <= 1'b0;
                    bus.resp_valid <= NUM_REQ'(1) << gidx;
                    bus.resp_result <= '0;
                    bus.resp_error <= ERR_FAIL;
                end
                // rejected operands enter RESP without a pulse and issue it one cycle later
                RESP: if (bus.resp_valid == '0) bus.resp_valid <= NUM_REQ'(1) << gidx;
                else begin
                    state <= IDLE;
                    ptr <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                    m_q <= '0;
                    e_q <= '0;
                    n_q <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modexp_arbiter.sv
// tb_modexp_arbiter: scoreboard bench with a behavioural square-and-multiply engine
module tb_modexp_arbiter;
    localparam int W = 16;
    typedef struct {int port; logic [W-1:0] res; logic err; logic chk;} exp_t;
    logic clk = 1'b0, reset = 1'b1;
    logic hang = 1'b0, stale = 1'b0, mvalid;
    logic [W-1:0] mres;
    int lat;
    int vectors = 0, miscompares = 0;
    exp_t sb[$];
    exp_t xe;

    modexp_arbiter_if #(.NUM_REQ(2), .WIDTH(W)) bus();
    modexp_arbiter #(.NUM_REQ(2), .WIDTH(W), .START_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [W-1:0] modexp(input logic [W-1:0] m, e, n);
        logic [31:0] r, b;
        r = 32'(1) % 32'(n);
        b = 32'(m) % 32'(n);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * b) % 32'(n);
            b = (b * b) % 32'(n);
        end
        return r[W-1:0];
    endfunction

    // engine: result appears a few cycles after start, valid is a level until restart/reset
    always @(posedge clk)
        if (bus.eng_reset) begin
            mvalid <= 1'b0;
            lat <= 0;
        end else if (bus.eng_ready) begin
            mvalid <= 1'b0;
            lat <= 3;
            mres <= modexp(bus.eng_m, bus.eng_e, bus.eng_n);
        end else if (lat > 0) begin
            lat <= lat - 1;
            if (lat == 1) mvalid <= !hang;
        end
    assign bus.eng_valid = mvalid | stale;
    assign bus.eng_result = stale ? 16'hBEEF : mres;

    always @(negedge clk)
        if (|bus.resp_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL resp_unexpected got resp_valid=%b, required none", bus.resp_valid);
            end else begin
                xe = sb.pop_front();
                if (bus.resp_valid !== 2'(1 << xe.port) || bus.resp_error !== xe.err ||
                    (xe.chk && bus.resp_result !== xe.res)) begin
                    miscompares++;
                    $display("FAIL resp_data got valid=%b err=%b res=%0d, required port=%0d err=%b res=%0d",
                             bus.resp_valid, bus.resp_error, bus.resp_result, xe.port, xe.err, xe.res);
                end
            end
        end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.eng_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_eng_reset got %b, required 1", bus.eng_reset);
        end
        vectors++;
        if ({bus.busy, bus.eng_ready, bus.req_ack, bus.resp_valid, bus.resp_error} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got busy=%b rdy=%b ack=%b resp=%b err=%b, required all 0",
                     bus.busy, bus.eng_ready, bus.req_ack, bus.resp_valid, bus.resp_error);
        end
        vectors++;
        if ({bus.eng_m, bus.eng_e, bus.eng_n, bus.resp_result} !== 64'b0) begin
            miscompares++;
            $display("FAIL reset_data got m=%0d e=%0d n=%0d res=%0d, required 0",
                     bus.eng_m, bus.eng_e, bus.eng_n, bus.resp_result);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.eng_reset !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release got eng_reset=%b busy=%b, required 0 0", bus.eng_reset, bus.busy);
        end
    endtask

    task automatic test_single(input int p, input logic [W-1:0] m, e, n, r);
        int ak = -1, rk = -1, vk = -1, rdy = 0;
        @(negedge clk);
        bus.req_m[p*W +: W] = m;
        bus.req_e[p*W +: W] = e;
        bus.req_n[p*W +: W] = n;
        bus.req_valid[p] = 1'b1;
        sb.push_back('{p, r, 1'b0, 1'b1});
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.req_ack[p] && ak < 0) begin
                ak = k;
                bus.req_valid[p] = 1'b0;
            end
            if (bus.eng_ready) rdy++;
            if (bus.eng_valid && k >= 3 && vk < 0) vk = k;
            if (bus.resp_valid[p]) begin
                rk = k;
                break;
            end
        end
        vectors++;
        if (ak !== 0) begin
            miscompares++;
            $display("FAIL single_ack port%0d got ack at +%0d, required +0", p, ak);
        end
        vectors++;
        if (rdy !== 2) begin
            miscompares++;
            $display("FAIL single_ready port%0d got %0d cycles, required 2", p, rdy);
        end
        vectors++;
        if (rk < 0 || rk !== vk + 1) begin
            miscompares++;
            $display("FAIL single_latency port%0d got resp at %0d, valid at %0d, required valid+1", p, rk, vk);
        end
    endtask

    task automatic test_fairness();
        int g[4] = '{-1, -1, -1, -1};
        int na = 0, nr = 0, raised = 2;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            bus.req_m[p*W +: W] = W'($urandom_range(0, 5000));
            bus.req_e[p*W +: W] = W'($urandom_range(0, 65535));
            bus.req_n[p*W +: W] = W'($urandom_range(2, 60000));
        end
        bus.req_valid = 2'b11;
        for (int k = 0; k < 400 && nr < 4; k++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (bus.req_ack[p]) begin
                    if (na < 4) g[na] = p;
                    na++;
                    bus.req_valid[p] = 1'b0;
                    sb.push_back('{p, modexp(bus.req_m[p*W +: W], bus.req_e[p*W +: W], bus.req_n[p*W +: W]),
                                   1'b0, 1'b1});
                end
                if (bus.resp_valid[p]) begin
                    nr++;
                    if (raised < 4) begin
                        raised++;
                        bus.req_m[p*W +: W] = W'($urandom_range(0, 5000));
                        bus.req_e[p*W +: W] = W'($urandom_range(0, 65535));
                        bus.req_n[p*W +: W] = W'($urandom_range(2, 60000));
                        bus.req_valid[p] = 1'b1;
                    end
                end
            end
        end
        vectors++;
        if (na !== 4) begin
            miscompares++;
            $display("FAIL fair_count got %0d grants, required 4", na);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (g[i] !== i % 2) begin
                miscompares++;
                $display("FAIL fair_order grant%0d got port %0d, required %0d", i, g[i], i % 2);
            end
        end
    endtask

    task automatic test_bad_modulus();
        int ak = -1, rk = -1, rdy = 0;
        @(negedge clk);
        bus.req_m[W-1:0] = 16'd7;
        bus.req_e[W-1:0] = 16'd9;
        bus.req_n[W-1:0] = 16'd1;
        bus.req_valid[0] = 1'b1;
        sb.push_back('{0, 16'd0, 1'b1, 1'b0});
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ack[0] && ak < 0) begin
                ak = k;
                bus.req_valid[0] = 1'b0;
            end
            if (bus.eng_ready) rdy++;
            if (bus.resp_valid[0]) begin
                rk = k;
                break;
            end
        end
        vectors++;
        if (ak !== 0 || rk !== 1) begin
            miscompares++;
            $display("FAIL badn_timing got ack +%0d resp +%0d, required +0 +1", ak, rk);
        end
        vectors++;
        if (rdy !== 0) begin
            miscompares++;
            $display("FAIL badn_ready got %0d ready cycles, required 0", rdy);
        end
    endtask

    task automatic test_timeout();
        int rs = -1, rc = 0, rk = -1;
        hang = 1'b1;
        @(negedge clk);
        bus.req_m[W-1:0] = 16'd3;
        bus.req_e[W-1:0] = 16'd5;
        bus.req_n[W-1:0] = 16'd7;
        bus.req_valid[0] = 1'b1;
        sb.push_back('{0, 16'd0, 1'b1, 1'b1});
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.req_ack[0]) bus.req_valid[0] = 1'b0;
            if (bus.eng_reset) begin
                rc++;
                if (rs < 0) rs = k;
            end
            if (bus.resp_valid[0]) begin
                rk = k;
                break;
            end
        end
        hang = 1'b0;
        vectors++;
        if (rs - 2 !== 64) begin
            miscompares++;
            $display("FAIL timeout_wait got %0d WAIT cycles, required 64", rs - 2);
        end
        vectors++;
        if (rc !== 2) begin
            miscompares++;
            $display("FAIL timeout_pulse got eng_reset for %0d cycles, required 2", rc);
        end
        vectors++;
        if (rk < 0 || rk !== rs + 2) begin
            miscompares++;
            $display("FAIL timeout_resp got resp at %0d, required %0d", rk, rs + 2);
        end
        test_single(1, 16'd5, 16'd3, 16'd13, 16'd8);
    endtask

    task automatic test_reset_mid_wait();
        int nresp = 0;
        @(negedge clk);
        bus.req_m[W +: W] = 16'd9;
        bus.req_e[W +: W] = 16'd10;
        bus.req_n[W +: W] = 16'd23;
        bus.req_valid[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.req_ack[1]) bus.req_valid[1] = 1'b0;
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.eng_reset !== 1'b1 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_assert got eng_reset=%b busy=%b, required 1 1", bus.eng_reset, bus.busy);
        end
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_idle got busy=%b, required 0", bus.busy);
        end
        repeat (10) begin
            @(negedge clk);
            if (|bus.resp_valid) nresp++;
        end
        vectors++;
        if (nresp !== 0) begin
            miscompares++;
            $display("FAIL midrst_noresp got %0d responses, required 0", nresp);
        end
    endtask

    task automatic test_stale_valid();
        int rk = -1;
        @(negedge clk);
        stale = 1'b1;
        bus.req_m[W-1:0] = 16'd12;
        bus.req_e[W-1:0] = 16'd56;
        bus.req_n[W-1:0] = 16'd99;
        bus.req_valid[0] = 1'b1;
        sb.push_back('{0, 16'd45, 1'b0, 1'b1});
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 3) stale = 1'b0;
            if (bus.req_ack[0]) bus.req_valid[0] = 1'b0;
            if (bus.resp_valid[0]) begin
                rk = k;
                break;
            end
        end
        stale = 1'b0;
        vectors++;
        if (rk <= 3) begin
            miscompares++;
            $display("FAIL stale_early got resp at +%0d, required later than +3", rk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got no completion, required finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = '0;
        bus.req_m = '0;
        bus.req_e = '0;
        bus.req_n = '0;
        test_reset();
        test_single(0, 16'd12, 16'd56, 16'd99, 16'd45);
        test_single(1, 16'd5, 16'd3, 16'd13, 16'd8);
        test_fairness();
        test_bad_modulus();
        test_timeout();
        test_reset_mid_wait();
        test_stale_valid();
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL sb_drain got %0d pending responses, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
